ander_serial: RTL and testbench
===============================

Name: ander_serial

Overview:
- Bit-serial counterpart to the parallel 4-bit AND array. It accepts two WIDTH-bit operands over a valid/ready handshake.
- The operands are shifted LSB-first through a single one-bit ander stage, one bit per clock, and the AND result is reassembled in a shift register.
- The result is presented on an output valid/ready handshake.
- Used where area matters more than latency, and as a cross-check against the parallel array.

Parameters:
- WIDTH, 4, operand/result width in bits; legal range 2..32.
- CW, 6, counter width; must satisfy 2**CW > WIDTH.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_a  input  WIDTH  operand A; sampled on accept.
- in_b  input  WIDTH  operand B; sampled on accept.
- in_valid  input  1  operands valid.
- in_ready  output  1  block can accept operands.
- out_result  output  WIDTH  in_a AND in_b, bitwise.
- out_valid  output  1  out_result valid.
- out_ready  input  1  downstream accepts result.
- ser_a  output  1  current serial bit of A (LSB of A shift register).
- ser_b  output  1  current serial bit of B.
- ser_r  output  1  current ander stage output (ser_a & ser_b).
- busy  output  1  high in SHIFT or DONE.

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Reset is sampled only on the rising edge of clk.
- Reset values:
  - in_ready=1, out_valid=0, busy=0.
  - out_result=0, ser_a=0, ser_b=0, ser_r=0.
  - Internal shift registers = 0, counter = 0, state = IDLE.
- State machine: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1, busy=0.
  - On an edge with in_valid=1: load sh_a<=in_a, sh_b<=in_b, sh_r<=0, cnt<=0; go to SHIFT.
  - If in_valid=0, remain in IDLE.
- SHIFT:
  - in_ready=0, busy=1.
  - Each edge: sh_r <= {ser_r, sh_r[WIDTH-1:1]} (MSB-in, so after WIDTH shifts bit i lands at position i).
  - Each edge: sh_a and sh_b shift right by one with zero fill; cnt<=cnt+1.
  - When cnt==WIDTH-1 at the edge, the last bit is shifted in and the state goes to DONE.
  - in_valid is ignored in SHIFT.
- DONE:
  - out_valid=1, out_result=sh_r, busy=1, in_ready=0.
  - out_result is held stable while out_valid=1 and out_ready=0 (no limit on stall length).
  - On an edge with out_ready=1: go to IDLE and clear out_valid. in_ready returns high the following cycle.
- Latency:
  - Accept edge E0.
  - out_valid high in the cycle after edge E0+WIDTH, i.e. WIDTH+1 cycles after in_valid is first seen with in_ready=1.
  - Minimum initiation interval is WIDTH+2 cycles.
- No overlap: a new operand pair cannot be accepted in the same cycle a result is consumed.
- ser_a/ser_b/ser_r:
  - Combinational from the shift-register LSBs; ser_r = ser_a & ser_b.
  - Valid in SHIFT only; 0 in IDLE and DONE, because the registers have shifted to zero.
- Width rules:
  - Result is exactly WIDTH bits; there is no carry or overflow.
  - cnt compares against WIDTH-1 at CW bits.
- Boundary conditions:
  - out_ready may be high before out_valid; this has no effect until DONE.
  - in_valid held high continuously: the next pair is accepted on the first IDLE edge after DONE.
  - Reset asserted in SHIFT or DONE: the in-flight operation is aborted with no result emitted, and all outputs take their reset values on the next edge.
  - Reset and in_valid in the same cycle: reset wins, nothing is accepted.
  - Reset and out_ready in the same cycle in DONE: reset wins; the result is dropped.
- out_result = 0 whenever out_valid = 0 (cleared on leaving DONE).

Test Plan:
- Basic accept/result (WIDTH=4): reset 2 cycles, then in_a=4'b1011, in_b=4'b0110, in_valid=1 for one cycle.
  - in_ready drops the next cycle.
  - ser_r sequence over 4 SHIFT cycles = 0,1,0,0.
  - out_valid=1 with out_result=4'b0010 exactly 5 cycles after accept.
- All-ones/all-zeros: in_a=4'hF, in_b=4'hF -> out_result=4'hF; then in_a=4'hF, in_b=4'h0 -> 4'h0.
  - in_ready re-rises exactly 1 cycle after each out handshake.
- Backpressure: in_a=4'hA, in_b=4'hE, out_ready=0 for 10 cycles in DONE.
  - out_valid and out_result=4'hA stay stable for all 10 cycles.
  - Raising out_ready completes the transfer in 1 cycle.
- Back-to-back: in_valid held high with 3 pairs (5/7, C/9, 3/3), out_ready=1.
  - Results are 5, 8, 3 in order.
  - Accept edges are spaced exactly 6 cycles apart.
- Reset mid-operation: assert reset in the 2nd SHIFT cycle.
  - Next cycle: out_valid=0, in_ready=1, busy=0.
  - No result appears; a subsequent pair 6/3 yields 2.
- Exhaustive random (WIDTH=4 and WIDTH=8 builds): 1000 random operand pairs with random in_valid/out_ready gaps.
  - Every out_result matches in_a & in_b.
  - No result is lost or duplicated.

Source files
------------

// File: rtl/ander_serial_if.sv
`default_nettype none
// ============================================================================
// Module      : ander_serial_if
// Description : Operand/result handshake bundle for the bit-serial AND block.
//               master : producer/consumer side (drives operands, out_ready)
//               slave  : ander_serial side (drives result, status, serial taps)
//   in_a/in_b   operands, in_valid/in_ready   input handshake
//   out_result  result,   out_valid/out_ready output handshake
//   ser_a/ser_b/ser_r  serial-stage taps, busy  operation in progress
// Revision    : 1.0 - initial release
// ============================================================================
interface ander_serial_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_valid;
  logic             out_ready;
  logic             ser_a;
  logic             ser_b;
  logic             ser_r;
  logic             busy;

  modport master (
    output in_a, in_b, in_valid, out_ready,
    input  in_ready, out_result, out_valid, ser_a, ser_b, ser_r, busy
  );

  modport slave (
    input  in_a, in_b, in_valid, out_ready,
    output in_ready, out_result, out_valid, ser_a, ser_b, ser_r, busy
  );
endinterface
`default_nettype wire

// File: rtl/ander_serial.sv
`default_nettype none
// ============================================================================
// Module      : ander_serial
// Description : Bit-serial bitwise AND of two WIDTH-bit operands. Operands are
//               shifted LSB-first through a single one-bit AND stage; the
//               result is rebuilt in a shift register and offered on an
//               output valid/ready handshake.
//   clk   : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : ander_serial_if.slave (operands, result, serial taps, busy)
// Revision    : 1.0 - initial release
// ============================================================================
module ander_serial #(
  parameter int WIDTH = 4,
  parameter int CW    = 6
) (
  input  wire logic         clk,
  input  wire logic         reset,
  ander_serial_if.slave     bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_sh_a;
  logic [WIDTH-1:0] r_sh_b;
  logic [WIDTH-1:0] r_sh_r;
  logic [CW-1:0]    r_cnt;
  logic             w_ser_r;

  // The operand registers empty themselves as they shift, so the taps read
  // zero outside SHIFT without any extra gating.
  assign bus.ser_a = r_sh_a[0];
  assign bus.ser_b = r_sh_b[0];
  assign w_ser_r   = r_sh_a[0] & r_sh_b[0];
  assign bus.ser_r = w_ser_r;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_sh_a  <= '0;
      r_sh_b  <= '0;
      r_sh_r  <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_sh_a <= bus.in_a;
            r_sh_b <= bus.in_b;
            r_sh_r <= '0;
            r_cnt  <= '0;
          end
        end
        S_SHIFT: begin
          // Result enters at the MSB so bit i settles at position i after
          // WIDTH shifts.
          r_sh_r <= {w_ser_r, r_sh_r[WIDTH-1:1]};
          r_sh_a <= {1'b0, r_sh_a[WIDTH-1:1]};
          r_sh_b <= {1'b0, r_sh_b[WIDTH-1:1]};
          r_cnt  <= r_cnt + 1'b1;
        end
        S_DONE: begin
          if (bus.out_ready) begin
            r_sh_r <= '0;
          end
        end
        default: begin
          r_sh_r <= '0;
        end
      endcase
    end
  end

  always_comb begin
    w_next_state   = r_state;
    bus.in_ready   = 1'b0;
    bus.busy       = 1'b0;
    bus.out_valid  = 1'b0;
    bus.out_result = '0;
    case (r_state)
      S_IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          w_next_state = S_SHIFT;
        end
      end
      S_SHIFT: begin
        bus.busy = 1'b1;
        if (r_cnt == C_LAST) begin
          w_next_state = S_DONE;
        end
      end
      S_DONE: begin
        bus.busy       = 1'b1;
        bus.out_valid  = 1'b1;
        bus.out_result = r_sh_r;
        if (bus.out_ready) begin
          w_next_state = S_IDLE;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_ander_serial.sv
`default_nettype none
// ============================================================================
// Module      : tb_ander_serial
// Description : Self-checking bench for ander_serial. Directed scenarios plus
//               randomized traffic scored against a queue of expected a & b.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ander_serial #(
  parameter int WIDTH = 4,
  parameter int CW    = 6,
  parameter int NRAND = 1000
);

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ander_serial_if #(.WIDTH(WIDTH)) bus ();

  ander_serial #(.WIDTH(WIDTH), .CW(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;
  logic [WIDTH-1:0] exp_q[$];

  task automatic tick();
    @(negedge clk);
  endtask

  // Drives one operation with out_ready low until the result appears;
  // returns result, cycles from accept edge to out_valid, and in_ready
  // in the cycle after the output handshake.
  task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       output logic [WIDTH-1:0] res, output int lat,
                       output logic rdy_after);
    int n;
    bus.in_a = a; bus.in_b = b; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 100) begin tick(); n++; end
    tick();
    bus.in_valid = 1'b0;
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 200) begin tick(); lat++; end
    res = bus.out_result;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    rdy_after = bus.in_ready;
  endtask

  task automatic test_reset();
    reset = 1'b1; bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.out_ready = 1'b0;
    tick(); tick();
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.out_result !== '0) begin failures++; $display("FAIL reset_out_result got=%h exp=0", bus.out_result); end
    checks++; if ({bus.ser_a, bus.ser_b, bus.ser_r} !== 3'b000) begin failures++;
      $display("FAIL reset_ser got=%b exp=000", {bus.ser_a, bus.ser_b, bus.ser_r}); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    logic [WIDTH-1:0] a, b, r;
    a = WIDTH'(4'b1011); b = WIDTH'(4'b0110); r = a & b;
    bus.in_a = a; bus.in_b = b; bus.in_valid = 1'b1;
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL basic_ready_pre got=%b exp=1", bus.in_ready); end
    tick();
    bus.in_valid = 1'b0;
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL basic_ready_drop got=%b exp=0", bus.in_ready); end
    for (int i = 0; i < WIDTH; i++) begin
      checks++;
      if ({bus.ser_a, bus.ser_b, bus.ser_r} !== {a[i], b[i], r[i]}) begin failures++;
        $display("FAIL basic_ser bit=%0d got=%b exp=%b", i, {bus.ser_a, bus.ser_b, bus.ser_r}, {a[i], b[i], r[i]}); end
      checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL basic_early_valid cyc=%0d got=%b exp=0", i, bus.out_valid); end
      tick();
    end
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL basic_valid got=%b exp=1", bus.out_valid); end
    checks++; if (bus.out_result !== WIDTH'(4'b0010)) begin failures++; $display("FAIL basic_result got=%h exp=2", bus.out_result); end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    checks++; if (bus.out_valid !== 1'b0 || bus.out_result !== '0) begin failures++;
      $display("FAIL basic_clear got=%b/%h exp=0/0", bus.out_valid, bus.out_result); end
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL basic_ready_back got=%b exp=1", bus.in_ready); end
  endtask

  task automatic test_ones_zeros();
    logic [WIDTH-1:0] res; int lat; logic rdy;
    for (int k = 0; k < 2; k++) begin
      do_op({WIDTH{1'b1}}, (k == 0) ? {WIDTH{1'b1}} : '0, res, lat, rdy);
      checks++; if (res !== ((k == 0) ? {WIDTH{1'b1}} : '0)) begin failures++; $display("FAIL ones_zeros_result k=%0d got=%h", k, res); end
      checks++; if (lat != WIDTH + 1) begin failures++; $display("FAIL ones_zeros_latency got=%0d exp=%0d", lat, WIDTH + 1); end
      checks++; if (rdy !== 1'b1) begin failures++; $display("FAIL ones_zeros_ready got=%b exp=1", rdy); end
    end
  endtask

  task automatic test_backpressure();
    logic [WIDTH-1:0] exp_r;
    int n;
    exp_r = WIDTH'(4'hA) & WIDTH'(4'hE);
    bus.in_a = WIDTH'(4'hA); bus.in_b = WIDTH'(4'hE); bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    tick();
    bus.in_valid = 1'b0;
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 100) begin tick(); n++; end
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_result !== exp_r) begin failures++;
        $display("FAIL backpressure_hold cyc=%0d got=%b/%h exp=1/%h", c, bus.out_valid, bus.out_result, exp_r); end
      tick();
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin failures++;
      $display("FAIL backpressure_release got valid=%b ready=%b exp 0/1", bus.out_valid, bus.in_ready); end
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] pa[3], pb[3];
    logic [WIDTH-1:0] got[$];
    int acc[3];
    int idx;
    logic take;
    pa[0] = WIDTH'(4'h5); pb[0] = WIDTH'(4'h7);
    pa[1] = WIDTH'(4'hC); pb[1] = WIDTH'(4'h9);
    pa[2] = WIDTH'(4'h3); pb[2] = WIDTH'(4'h3);
    idx = 0;
    bus.out_ready = 1'b1; bus.in_valid = 1'b1; bus.in_a = pa[0]; bus.in_b = pb[0];
    for (int c = 0; c < 200 && got.size() < 3; c++) begin
      if (bus.out_valid === 1'b1) got.push_back(bus.out_result);
      take = (idx < 3) && (bus.in_ready === 1'b1);
      if (take) acc[idx] = c;
      tick();
      if (take) begin
        idx++;
        if (idx < 3) begin bus.in_a = pa[idx]; bus.in_b = pb[idx]; end
        else bus.in_valid = 1'b0;
      end
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    checks++; if (got.size() != 3) begin failures++; $display("FAIL b2b_count got=%0d exp=3", got.size()); end
    for (int k = 0; k < got.size() && k < 3; k++) begin
      checks++; if (got[k] !== (pa[k] & pb[k])) begin failures++; $display("FAIL b2b_result k=%0d got=%h exp=%h", k, got[k], pa[k] & pb[k]); end
    end
    if (idx == 3) begin
      for (int k = 1; k < 3; k++) begin
        checks++; if (acc[k] - acc[k-1] != WIDTH + 2) begin failures++;
          $display("FAIL b2b_spacing k=%0d got=%0d exp=%0d", k, acc[k] - acc[k-1], WIDTH + 2); end
      end
    end else begin
      checks++; failures++; $display("FAIL b2b_accepts got=%0d exp=3", idx);
    end
  endtask

  task automatic test_reset_mid();
    logic [WIDTH-1:0] res; int lat; logic rdy; int seen; int n;
    // Reset lands in the second SHIFT cycle.
    bus.in_a = '1; bus.in_b = '1; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin failures++;
      $display("FAIL reset_mid_state got v=%b r=%b b=%b exp 0/1/0", bus.out_valid, bus.in_ready, bus.busy); end
    seen = 0;
    for (int c = 0; c < WIDTH + 4; c++) begin if (bus.out_valid === 1'b1) seen++; tick(); end
    checks++; if (seen != 0) begin failures++; $display("FAIL reset_mid_ghost got=%0d exp=0", seen); end
    bus.out_ready = 1'b0;
    // Reset together with in_valid: nothing accepted.
    reset = 1'b1; bus.in_valid = 1'b1;
    tick();
    reset = 1'b0; bus.in_valid = 1'b0;
    checks++; if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin failures++;
      $display("FAIL reset_with_valid got r=%b b=%b exp 1/0", bus.in_ready, bus.busy); end
    // Reset together with out_ready in DONE: result dropped.
    bus.in_a = '1; bus.in_b = '1; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 100) begin tick(); n++; end
    reset = 1'b1; bus.out_ready = 1'b1;
    tick();
    reset = 1'b0; bus.out_ready = 1'b0;
    checks++; if (bus.out_valid !== 1'b0 || bus.out_result !== '0 || bus.in_ready !== 1'b1) begin failures++;
      $display("FAIL reset_in_done got v=%b res=%h r=%b exp 0/0/1", bus.out_valid, bus.out_result, bus.in_ready); end
    do_op(WIDTH'(4'h6), WIDTH'(4'h3), res, lat, rdy);
    checks++; if (res !== WIDTH'(4'h2)) begin failures++; $display("FAIL reset_mid_after got=%h exp=2", res); end
  endtask

  task automatic test_random();
    int rcv;
    int budget;
    int limit;
    rcv = 0; budget = 0;
    limit = NRAND * (WIDTH + 12) + 1000;
    exp_q.delete();
    fork
      begin : driver
        logic [WIDTH-1:0] a, b;
        int w;
        for (int i = 0; i < NRAND; i++) begin
          bus.in_valid = 1'b0;
          repeat ($urandom_range(0, 3)) tick();
          a = WIDTH'($urandom); b = WIDTH'($urandom);
          bus.in_a = a; bus.in_b = b; bus.in_valid = 1'b1;
          w = 0;
          while (bus.in_ready !== 1'b1 && w < 500) begin tick(); w++; end
          if (w >= 500) begin
            checks++; failures++; $display("FAIL rand_accept_timeout op=%0d got=stalled exp=accept", i);
            break;
          end
          exp_q.push_back(a & b);
          tick();
        end
        bus.in_valid = 1'b0;
      end
      begin : monitor
        logic [WIDTH-1:0] e;
        while (rcv < NRAND && budget < limit) begin
          bus.out_ready = ($urandom_range(0, 3) != 0);
          if (bus.out_valid === 1'b1) begin
            if (bus.out_ready) begin
              checks++;
              if (exp_q.size() == 0) begin failures++; $display("FAIL rand_extra got=%h exp=none", bus.out_result); end
              else begin
                e = exp_q.pop_front();
                if (bus.out_result !== e) begin failures++; $display("FAIL rand_result n=%0d got=%h exp=%h", rcv, bus.out_result, e); end
              end
              rcv++;
            end
          end else begin
            checks++;
            if (bus.out_result !== '0) begin failures++; $display("FAIL rand_idle_result got=%h exp=0", bus.out_result); end
          end
          tick();
          budget++;
        end
      end
    join
    bus.out_ready = 1'b1;
    repeat (WIDTH + 4) tick();
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rand_dup got=%b exp=0", bus.out_valid); end
    bus.out_ready = 1'b0;
    checks++; if (rcv != NRAND) begin failures++; $display("FAIL rand_count got=%0d exp=%0d", rcv, NRAND); end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL rand_leftover got=%0d exp=0", exp_q.size()); end
  endtask

  initial begin
    #(900_000);
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_ones_zeros();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
